// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmds_pkg
// Brief    : Shared TMDS types, symbol constants and encoder helper functions.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
package tmds_pkg;

    typedef enum logic [1:0] {
        CTRL  = 2'd0,
        VIDEO = 2'd1,
        TERC4 = 2'd2,
        GUARD = 2'd3
    } tmds_mode_t;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] VGB_CH0_2 = 10'b1011001100;
    localparam logic [9:0] VGB_CH1   = 10'b0100110011;
    localparam logic [9:0] DIGB      = 10'b0100110011;

    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, d[i]};
        end
        return s;
    endfunction

    // Transition-minimising stage: bit 8 is 1 when the XOR chain was used.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [8:0] q;
        logic       xn;
        logic [3:0] n1;
        n1   = popcount8(d);
        xn   = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~xn;
        return q;
    endfunction

endpackage : tmds_pkg
`default_nettype wire

// File: rtl/tmds_lane_enc.sv
`default_nettype none
// ============================================================================
// Module   : tmds_lane_enc
// Brief    : One TMDS lane: q_m stage, running disparity, mode mux, output reg.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter int LANE_IDX     = 0,
    parameter int GB_DI_CH0_EN = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [1:0] mode_in,
    input  logic       gb_di_in,
    input  logic [7:0] data_in,
    input  logic [1:0] control_in,
    input  logic [3:0] terc_in,
    output logic [9:0] tmds_out
);

    localparam logic [9:0] c_vgb_sym = ((LANE_IDX % 3) == 1) ? VGB_CH1 : VGB_CH0_2;

    tmds_mode_t        w_mode;
    logic [8:0]        w_qm;
    logic [3:0]        w_n1;
    logic signed [4:0] w_n1s;
    logic signed [4:0] w_n0s;
    logic signed [4:0] w_diff;
    logic [9:0]        w_sym;
    logic signed [4:0] w_cnt_nxt;

    logic [9:0]        r_tmds;
    logic signed [4:0] r_cnt;

    assign w_mode = tmds_mode_t'(mode_in);
    assign w_qm   = tmds_qm(data_in);
    assign w_n1   = popcount8(w_qm[7:0]);
    assign w_n1s  = signed'({1'b0, w_n1});
    assign w_n0s  = 5'sd8 - w_n1s;
    assign w_diff = w_n1s - w_n0s;

    always_comb begin
        w_sym     = CTRL_00;
        w_cnt_nxt = 5'sd0;
        case (w_mode)
            CTRL: begin
                case (control_in)
                    2'b00:   w_sym = CTRL_00;
                    2'b01:   w_sym = CTRL_01;
                    2'b10:   w_sym = CTRL_10;
                    default: w_sym = CTRL_11;
                endcase
            end
            VIDEO: begin
                if ((r_cnt == 5'sd0) || (w_n1 == 4'd4)) begin
                    w_sym     = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
                    w_cnt_nxt = r_cnt + (w_qm[8] ? w_diff : -w_diff);
                end else if (((r_cnt > 5'sd0) && (w_n1 > 4'd4)) ||
                             ((r_cnt < 5'sd0) && (w_n1 < 4'd4))) begin
                    w_sym     = {1'b1, w_qm[8], ~w_qm[7:0]};
                    w_cnt_nxt = r_cnt + (w_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
                end else begin
                    w_sym     = {1'b0, w_qm[8], w_qm[7:0]};
                    w_cnt_nxt = r_cnt + w_diff - (w_qm[8] ? 5'sd0 : 5'sd2);
                end
            end
            TERC4: begin
                w_sym = TERC4_TAB[terc_in];
            end
            default: begin
                // Only lane 0 carries header TERC4 during a data-island guard band.
                if (!gb_di_in) begin
                    w_sym = c_vgb_sym;
                end else if (LANE_IDX == 0) begin
                    w_sym = (GB_DI_CH0_EN != 0) ? TERC4_TAB[terc_in] : VGB_CH0_2;
                end else begin
                    w_sym = DIGB;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tmds <= CTRL_00;
            r_cnt  <= 5'sd0;
        end else begin
            r_tmds <= w_sym;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign tmds_out = r_tmds;

endmodule : tmds_lane_enc
`default_nettype wire

// File: rtl/tmds_encoder_mc.sv
`default_nettype none
// ============================================================================
// Module   : tmds_encoder_mc
// Brief    : NUM_CH-lane TMDS/HDMI encoder (CTRL, VIDEO, TERC4, GUARD modes).
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int GB_DI_CH0_EN = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [1:0]            mode_in,
    input  logic                  gb_di_in,
    input  logic [8*NUM_CH-1:0]   data_in,
    input  logic [2*NUM_CH-1:0]   control_in,
    input  logic [4*NUM_CH-1:0]   terc_in,
    output logic [10*NUM_CH-1:0]  tmds_out
);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
            tmds_lane_enc #(
                .LANE_IDX     (k),
                .GB_DI_CH0_EN (GB_DI_CH0_EN)
            ) u_lane (
                .clk_in     (clk_in),
                .rst_in     (rst_in),
                .mode_in    (mode_in),
                .gb_di_in   (gb_di_in),
                .data_in    (data_in[8*k +: 8]),
                .control_in (control_in[2*k +: 2]),
                .terc_in    (terc_in[4*k +: 4]),
                .tmds_out   (tmds_out[10*k +: 10])
            );
        end
    endgenerate

endmodule : tmds_encoder_mc
`default_nettype wire

// File: tb/tb_tmds_encoder_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_encoder_mc
// Brief    : Scoreboard bench: 4-lane (CH0 TERC4 guard) and 1-lane encoders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_encoder_mc;

    localparam logic [1:0] M_CTRL  = 2'd0;
    localparam logic [1:0] M_VIDEO = 2'd1;
    localparam logic [1:0] M_TERC  = 2'd2;
    localparam logic [1:0] M_GUARD = 2'd3;

    localparam logic [9:0] T_TAB [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };
    localparam logic [9:0] C_TAB [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [1:0]  mode_in;
    logic        gb_di_in;
    logic [31:0] data4;
    logic [7:0]  ctrl4;
    logic [15:0] terc4;
    logic [39:0] tmds4_out;
    logic [9:0]  tmds1_out;

    logic [49:0] sb_q [$];
    logic [49:0] exp_v;
    int          m_cnt [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk_in = ~clk_in;

    tmds_encoder_mc #(.NUM_CH(4), .GB_DI_CH0_EN(1)) u_dut4 (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .mode_in    (mode_in),
        .gb_di_in   (gb_di_in),
        .data_in    (data4),
        .control_in (ctrl4),
        .terc_in    (terc4),
        .tmds_out   (tmds4_out)
    );

    tmds_encoder_mc #(.NUM_CH(1), .GB_DI_CH0_EN(0)) u_dut1 (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .mode_in    (mode_in),
        .gb_di_in   (gb_di_in),
        .data_in    (data4[7:0]),
        .control_in (ctrl4[1:0]),
        .terc_in    (terc4[3:0]),
        .tmds_out   (tmds1_out)
    );

    function automatic logic [9:0] model_video(int k, logic [7:0] d);
        logic [8:0] q;
        logic       par;
        logic       xn;
        logic [9:0] o;
        int         n1, big_n1, big_n0;
        n1  = $countones(d);
        xn  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        par = 1'b0;
        q   = '0;
        for (int i = 0; i < 8; i++) begin
            par  = par ^ d[i];
            q[i] = xn ? (par ^ i[0]) : par;
        end
        q[8]   = ~xn;
        big_n1 = $countones(q[7:0]);
        big_n0 = 8 - big_n1;
        if (m_cnt[k] == 0 || big_n1 == big_n0) begin
            o = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            m_cnt[k] += q[8] ? (big_n1 - big_n0) : (big_n0 - big_n1);
        end else if ((m_cnt[k] > 0 && big_n1 > big_n0) || (m_cnt[k] < 0 && big_n0 > big_n1)) begin
            o = {1'b1, q[8], ~q[7:0]};
            m_cnt[k] += (q[8] ? 2 : 0) + big_n0 - big_n1;
        end else begin
            o = {1'b0, q[8], q[7:0]};
            m_cnt[k] += big_n1 - big_n0 - (q[8] ? 0 : 2);
        end
        return o;
    endfunction

    function automatic logic [9:0] model_sym(int k, logic [1:0] m, logic gb,
                                             logic [7:0] d, logic [1:0] c, logic [3:0] t);
        if (m == M_VIDEO) return model_video(k, d);
        m_cnt[k] = 0;
        case (m)
            M_CTRL:  return C_TAB[c];
            M_TERC:  return T_TAB[t];
            default: begin
                if (!gb) return ((k % 3) == 1) ? 10'h133 : 10'h2CC;
                if (k == 0) return T_TAB[t];
                return 10'h133;
            end
        endcase
    endfunction

    // Drive one cycle of inputs, push the predicted symbols, then wait past the edge.
    task automatic step(logic [1:0] m, logic gb, logic [31:0] d, logic [7:0] c, logic [15:0] t);
        logic [39:0] e4;
        logic [9:0]  e1;
        mode_in  = m;
        gb_di_in = gb;
        data4    = d;
        ctrl4    = c;
        terc4    = t;
        for (int k = 0; k < 4; k++) begin
            e4[10*k +: 10] = model_sym(k, m, gb, d[8*k +: 8], c[2*k +: 2], t[4*k +: 4]);
        end
        e1 = (m == M_GUARD && gb) ? 10'h2CC : e4[9:0];
        sb_q.push_back({e1, e4});
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step(M_CTRL, 1'b0, 32'h0, 8'h0, 16'h0);
        void'(sb_q.pop_front());
        n_checks++;
        if ({tmds1_out, tmds4_out} !== {5{10'h354}}) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected %h", {tmds1_out, tmds4_out}, {5{10'h354}});
        end
        rst_in = 1'b0;
        clear_model();
        for (int n = 0; n < 6; n++) begin
            step(M_VIDEO, 1'b0, $urandom, 8'h0, 16'h0);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({tmds1_out, tmds4_out} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_prevideo n=%0d: got %h expected %h", n, {tmds1_out, tmds4_out}, exp_v);
            end
        end
        rst_in = 1'b1;
        #1;
        n_checks++;
        if ({tmds1_out, tmds4_out} !== {5{10'h354}}) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", {tmds1_out, tmds4_out}, {5{10'h354}});
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        clear_model();
        step(M_VIDEO, 1'b0, 32'h0, 8'h0, 16'h0);
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({tmds1_out, tmds4_out} !== {5{10'h100}} || exp_v !== {5{10'h100}}) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", {tmds1_out, tmds4_out}, {5{10'h100}});
        end
    endtask

    task automatic test_video_zero();
        logic [9:0] want [3];
        want = '{10'h100, 10'h3FF, 10'h100};
        step(M_CTRL, 1'b0, 32'h0, 8'h0, 16'h0);
        exp_v = sb_q.pop_front();
        for (int n = 0; n < 3; n++) begin
            step(M_VIDEO, 1'b0, 32'h0, 8'h0, 16'h0);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (tmds4_out[9:0] !== want[n] || {tmds1_out, tmds4_out} !== exp_v) begin
                n_fail++;
                $display("FAIL video_zero n=%0d: got %h expected lane0 %h", n, {tmds1_out, tmds4_out}, want[n]);
            end
        end
    endtask

    task automatic test_ctrl();
        for (int c = 0; c < 4; c++) begin
            step(M_CTRL, 1'b0, 32'hFFFF_FFFF, {4{c[1:0]}}, 16'h0);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({tmds1_out, tmds4_out} !== {5{C_TAB[c]}} || exp_v !== {5{C_TAB[c]}}) begin
                n_fail++;
                $display("FAIL ctrl c=%0d: got %h expected %h", c, {tmds1_out, tmds4_out}, {5{C_TAB[c]}});
            end
        end
        step(M_VIDEO, 1'b0, 32'h0, 8'h0, 16'h0);
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({tmds1_out, tmds4_out} !== {5{10'h100}}) begin
            n_fail++;
            $display("FAIL ctrl_then_video: got %h expected %h", {tmds1_out, tmds4_out}, {5{10'h100}});
        end
    endtask

    task automatic test_terc4();
        logic [15:0] t;
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 4; k++) t[4*k +: 4] = 4'((n + 5 * k) % 16);
            step(M_TERC, 1'b0, $urandom, 8'h0, t);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({tmds1_out, tmds4_out} !== exp_v) begin
                n_fail++;
                $display("FAIL terc4 n=%0d: got %h expected %h", n, {tmds1_out, tmds4_out}, exp_v);
            end
        end
        step(M_TERC, 1'b0, 32'h0, 8'h0, 16'h0);
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({tmds1_out, tmds4_out} !== {5{10'h29C}}) begin
            n_fail++;
            $display("FAIL terc4_zero: got %h expected %h", {tmds1_out, tmds4_out}, {5{10'h29C}});
        end
    endtask

    task automatic test_guard();
        step(M_GUARD, 1'b0, 32'h0, 8'h0, 16'hFFFF);
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({tmds1_out, tmds4_out} !== {10'h2CC, 10'h2CC, 10'h2CC, 10'h133, 10'h2CC}) begin
            n_fail++;
            $display("FAIL guard_video: got %h expected %h", {tmds1_out, tmds4_out},
                     {10'h2CC, 10'h2CC, 10'h2CC, 10'h133, 10'h2CC});
        end
        step(M_GUARD, 1'b1, 32'h0, 8'h0, 16'h123C);
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({tmds1_out, tmds4_out} !== {10'h2CC, 10'h133, 10'h133, 10'h133, 10'h28E}) begin
            n_fail++;
            $display("FAIL guard_island: got %h expected %h", {tmds1_out, tmds4_out},
                     {10'h2CC, 10'h133, 10'h133, 10'h133, 10'h28E});
        end
    endtask

    task automatic test_video_sweep();
        logic [31:0] d;
        for (int b = 0; b < 256; b++) begin
            for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'((b + 73 * k) % 256) ^ 8'(k * 8'h5A);
            step(M_VIDEO, 1'b0, d, 8'h0, 16'h0);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({tmds1_out, tmds4_out} !== exp_v) begin
                n_fail++;
                $display("FAIL video_sweep b=%0d: got %h expected %h", b, {tmds1_out, tmds4_out}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] m;
        for (int n = 0; n < 600; n++) begin
            m = ($urandom_range(0, 7) == 0) ? 2'($urandom) : M_VIDEO;
            step(m, 1'($urandom), $urandom, 8'($urandom), 16'($urandom));
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({tmds1_out, tmds4_out} !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back n=%0d mode=%0d: got %h expected %h", n, m,
                         {tmds1_out, tmds4_out}, exp_v);
            end
        end
    endtask

    initial begin
        rst_in   = 1'b1;
        mode_in  = M_CTRL;
        gb_di_in = 1'b0;
        data4    = '0;
        ctrl4    = '0;
        terc4    = '0;
        clear_model();
        #1;
        n_checks++;
        if ({tmds1_out, tmds4_out} !== {5{10'h354}}) begin
            n_fail++;
            $display("FAIL reset_no_edge: got %h expected %h", {tmds1_out, tmds4_out}, {5{10'h354}});
        end
        test_reset();
        test_video_zero();
        test_ctrl();
        test_terc4();
        test_guard();
        test_video_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tmds_encoder_mc
`default_nettype wire
